// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, opcodes,
// funct codes, ALU codes, datapath select values and the per-state Moore decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd6;
  localparam logic [3:0] AluSlt = 4'd7;
  localparam logic [3:0] AluNor = 4'd12;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_control;
  } ctrl_t;

  // Unconditional Moore outputs only; the MemReady/Zero-gated strobes are added in the top.
  function automatic ctrl_t ctrl_decode(state_e st);
    ctrl_t c;
    c = '0;
    c.alu_control = AluAdd;
    case (st)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SrcBFour;
        c.pc_source = PcSrcAlu;
      end
      StDecode: c.alu_src_b = SrcBImmSh;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SrcBReg;
        c.alu_control = AluSub;
        c.pc_source   = PcSrcAluOut;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StAddiWb: c.reg_write = 1'b1;
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = PcSrcJump;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type Funct to ALU operation decode; flags any funct the ALU does not support.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = AluAdd;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FnAnd:   alu_control_o = AluAnd;
      FnOr:    alu_control_o = AluOr;
      FnAdd:   alu_control_o = AluAdd;
      FnSub:   alu_control_o = AluSub;
      FnSlt:   alu_control_o = AluSlt;
      FnNor:   alu_control_o = AluNor;
      default: funct_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: fetch/decode/execute/memory/write-back sequencing with
// memory ready handshakes, branch resolution on Zero and a sticky illegal-instruction trap.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic       illegal_q;
  logic [3:0] exec_alu;
  logic       funct_illegal;

  alu_decoder u_alu_decoder (
    .funct_i        (Funct),
    .alu_control_o  (exec_alu),
    .funct_illegal_o(funct_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (MemReady) state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (Opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (MemReady) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (MemReady) state_d = StFetch;
      StExec:   state_d = funct_illegal ? StTrap : StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  // Moore outputs are registered alongside the state so they leave flops directly.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= StFetch;
      ctrl_q    <= ctrl_decode(StFetch);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_decode(state_d);
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

  logic in_fetch, in_branch, in_exec;
  assign in_fetch  = (state_q == StFetch);
  assign in_branch = (state_q == StBranch);
  assign in_exec   = (state_q == StExec);

  // Enables are masked by Reset_n so an in-flight memory access drops immediately.
  assign PCWrite  = Reset_n & (ctrl_q.pc_write | (in_fetch & MemReady) | (in_branch & Zero));
  assign IRWrite  = Reset_n & in_fetch & MemReady;
  assign MemRead  = Reset_n & ctrl_q.mem_read;
  assign MemWrite = Reset_n & ctrl_q.mem_write;
  assign RegWrite = Reset_n & ctrl_q.reg_write;
  assign Illegal  = Reset_n & illegal_q;

  assign IorD       = ctrl_q.iord;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign PCSource   = ctrl_q.pc_source;
  assign ALUControl = in_exec ? exec_alu : ctrl_q.alu_control;
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus walks each instruction through its expected phases and queues
// the per-cycle expected outputs; a monitor pops and compares on every falling edge.
module tb_multicycle_control;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUControl, State;
  logic       Illegal;

  multicycle_control dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .PCSource  (PCSource),
    .ALUControl(ALUControl),
    .Illegal   (Illegal),
    .State     (State)
  );

  always #5 Clock = ~Clock;

  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
  localparam int SExec = 6, SAluWb = 7, SBranch = 8, SAddiEx = 9, SAddiWb = 10, SJump = 11;
  localparam int STrap = 12;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, mr, mw, irw, rdst, m2r, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aluc;
    logic       ill;
  } obs_t;

  typedef struct {
    bit    chk;
    obs_t  o;
    string tag;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle_no = 0;
  logic [5:0] cur_op, cur_fn;
  bit         cur_z;
  bit         trapped;

  logic [5:0] fn_tab   [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
  logic [3:0] code_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

  function automatic bit fn_legal(logic [5:0] fn);
    foreach (fn_tab[i]) if (fn_tab[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] fn_code(logic [5:0] fn);
    foreach (fn_tab[i]) if (fn_tab[i] == fn) return code_tab[i];
    return 4'd2;
  endfunction

  // Expected outputs for a cycle spent in state st with the given inputs.
  function automatic obs_t model(int st, bit rdy, bit z, logic [5:0] fn, bit rn);
    obs_t e;
    e = '0;
    e.st = 4'(st);
    e.aluc = 4'd2;
    case (st)
      SFetch:  begin e.mr = 1; e.srcb = 2'd1; e.irw = rdy; e.pcw = rdy; end
      SDecode: e.srcb = 2'd3;
      SMemAdr: begin e.srca = 1; e.srcb = 2'd2; end
      SMemRd:  begin e.mr = 1; e.iord = 1; end
      SMemWb:  begin e.rw = 1; e.m2r = 1; end
      SMemWr:  begin e.mw = 1; e.iord = 1; end
      SExec:   begin e.srca = 1; e.aluc = fn_code(fn); end
      SAluWb:  begin e.rw = 1; e.rdst = 1; end
      SBranch: begin e.srca = 1; e.aluc = 4'd6; e.pcsrc = 2'd1; e.pcw = z; end
      SAddiEx: begin e.srca = 1; e.srcb = 2'd2; end
      SAddiWb: e.rw = 1;
      SJump:   begin e.pcw = 1; e.pcsrc = 2'd2; end
      STrap:   e.ill = 1;
      default: ;
    endcase
    if (!rn) begin
      e.pcw = 0; e.mr = 0; e.mw = 0; e.irw = 0; e.rw = 0; e.ill = 0;
    end
    return e;
  endfunction

  task automatic cyc(int st, bit rdy, bit rn, bit chk, string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset_n  = rn;
    MemReady = rdy;
    Zero     = cur_z;
    Opcode   = cur_op;
    Funct    = cur_fn;
    e.chk = chk;
    e.o   = model(st, rdy, cur_z, cur_fn, rn);
    e.tag = $sformatf("%s st%0d cyc%0d", tag, st, cycle_no);
    cycle_no++;
    sb.push_back(e);
  endtask

  task automatic plain(int st, string tag);
    cyc(st, 1'($urandom_range(0, 1)), 1'b1, 1'b1, tag);
  endtask

  task automatic mem(int st, int waits, string tag);
    repeat (waits) cyc(st, 1'b0, 1'b1, 1'b1, tag);
    cyc(st, 1'b1, 1'b1, 1'b1, tag);
  endtask

  task automatic instr(logic [5:0] op, logic [5:0] fn, bit z, int wf, int wm, string tag);
    cur_op = op;
    cur_fn = fn;
    cur_z  = z;
    mem(SFetch, wf, tag);
    plain(SDecode, tag);
    case (op)
      6'h23: begin plain(SMemAdr, tag); mem(SMemRd, wm, tag); plain(SMemWb, tag); end
      6'h2B: begin plain(SMemAdr, tag); mem(SMemWr, wm, tag); end
      6'h00: begin
        plain(SExec, tag);
        if (fn_legal(fn)) plain(SAluWb, tag);
        else trapped = 1'b1;
      end
      6'h04: plain(SBranch, tag);
      6'h08: begin plain(SAddiEx, tag); plain(SAddiWb, tag); end
      6'h02: plain(SJump, tag);
      default: trapped = 1'b1;
    endcase
  endtask

  task automatic trap_and_reset(int n);
    repeat (n) plain(STrap, "trap");
    cyc(STrap, 1'($urandom_range(0, 1)), 1'b0, 1'b1, "trap reset");
    trapped = 1'b0;
  endtask

  // Monitor: compare every DUT cycle that has a queued expectation.
  initial begin
    obs_t act;
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, PCSource, ALUControl, Illegal};
          checks++;
          if (act !== e.o) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", e.tag, act,
                     act.st, e.o, e.o.st);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] op_tab [7] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    logic [5:0] op, fn;
    cur_op = 6'h00;
    cur_fn = 6'h22;
    cur_z = 1'b0;
    trapped = 1'b0;

    cyc(SFetch, 1'b1, 1'b0, 1'b1, "reset");
    cyc(SFetch, 1'b1, 1'b0, 1'b1, "reset");

    instr(6'h00, 6'h22, 1'b0, 0, 0, "rtype sub");
    instr(6'h23, 6'h00, 1'b0, 0, 3, "lw wait3");
    instr(6'h2B, 6'h00, 1'b0, 1, 2, "sw");
    instr(6'h04, 6'h00, 1'b1, 0, 0, "beq taken");
    instr(6'h04, 6'h00, 1'b0, 0, 0, "beq not taken");
    instr(6'h08, 6'h00, 1'b0, 2, 0, "addi");
    instr(6'h02, 6'h00, 1'b0, 0, 0, "jump");
    foreach (fn_tab[i]) instr(6'h00, fn_tab[i], 1'b0, 0, 0, "funct sweep");
    instr(6'h00, 6'h03, 1'b0, 0, 0, "bad funct");
    trap_and_reset(3);
    instr(6'h3F, 6'h20, 1'b0, 0, 0, "bad opcode");
    trap_and_reset(2);

    // sw interrupted by reset while waiting for memory
    cur_op = 6'h2B;
    cur_fn = 6'h00;
    cur_z = 1'b0;
    mem(SFetch, 0, "sw abort");
    plain(SDecode, "sw abort");
    plain(SMemAdr, "sw abort");
    cyc(SMemWr, 1'b0, 1'b1, 1'b1, "sw abort");
    cyc(SMemWr, 1'b0, 1'b1, 1'b1, "sw abort");
    cyc(SMemWr, 1'b0, 1'b0, 1'b1, "sw abort reset");

    for (int k = 0; k < 150; k++) begin
      op = op_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 15) == 0) begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 || op == 6'h23 ||
            op == 6'h2B) op = 6'h3F;
      end
      fn = fn_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
            "random");
      if (trapped) trap_and_reset($urandom_range(1, 3));
    end

    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
